// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Brief    : APB3 completer holding NUM_REGS word registers with registered
//            outputs and PSLVERR on bad addresses. Defining APB_SLV_WAIT_EN
//            inserts WAIT_CYCLES wait states into every transfer.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned IDX_W   = $clog2(NUM_REGS);
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_MSB = IDX_W + 1;

`ifdef APB_SLV_WAIT_EN
    localparam int unsigned WCNT_W    = 4;
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;
`else
    // Zero-wait build: the wait count has no effect on the hardware.
    localparam int unsigned c_unused_wait_cycles = WAIT_CYCLES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
`ifdef APB_SLV_WAIT_EN
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
`endif

    logic                    w_setup;
    logic                    w_access;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_err;
    logic                    w_src_err;
    logic                    w_src_wr;
    logic [IDX_W-1:0]        w_src_idx;
    logic                    w_load_ready;

    assign w_setup  = PSEL & ~PENABLE;
    assign w_access = PSEL & PENABLE;
    assign w_idx    = PADDR[IDX_MSB:IDX_LSB];

    // With NUM_REGS a power of two the index field spans exactly the bank,
    // so an out-of-range index always shows up as a nonzero bit above it.
    assign w_err = (PADDR[1:0] != 2'b00) ||
                   (PADDR[ADDR_WIDTH-1:IDX_MSB+1] != '0);

    // Entering READY straight from IDLE uses the live bus; from WAIT it uses
    // the values captured during setup.
    assign w_src_err = (state_q == ST_IDLE) ? w_err  : err_q;
    assign w_src_wr  = (state_q == ST_IDLE) ? PWRITE : pwrite_q;
    assign w_src_idx = (state_q == ST_IDLE) ? w_idx  : idx_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_d        = err_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        prdata_d     = '0;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        regs_d       = regs_q;
        w_load_ready = 1'b0;
`ifdef APB_SLV_WAIT_EN
        wcnt_d       = wcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_setup) begin
                    idx_d    = w_idx;
                    err_d    = w_err;
                    pwrite_d = PWRITE;
                    pwdata_d = PWDATA;
`ifdef APB_SLV_WAIT_EN
                    if (WAIT_CYCLES != 0) begin
                        wcnt_d  = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        w_load_ready = 1'b1;
                    end
`else
                    w_load_ready = 1'b1;
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (PENABLE) begin
                    if (wcnt_q == '0) begin
                        w_load_ready = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
            end
`endif
            ST_READY: begin
                state_d = ST_IDLE;
                // A dropped PSEL here aborts the transfer without a commit.
                if (w_access && pwrite_q && !err_q) begin
                    regs_d[idx_q] = pwdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_load_ready) begin
            state_d   = ST_READY;
            pready_d  = 1'b1;
            pslverr_d = w_src_err;
            prdata_d  = (w_src_err || w_src_wr) ? '0 : regs_q[w_src_idx];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            err_q     <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            regs_q    <= '{default: '0};
`ifdef APB_SLV_WAIT_EN
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            regs_q    <= regs_d;
`ifdef APB_SLV_WAIT_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Brief    : Directed self-checking bench for apb_slave_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif
    localparam int WAIT_LIMIT = 20;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks   = 0;
    int failures = 0;

    apb_slave_regfile #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .NUM_REGS    (16),
        .WAIT_CYCLES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One full transfer; for reads 'data' is the expected PRDATA.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input string tag);
        int waits;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wr ? data : 32'h0;
        tick();
        PENABLE = 1'b1;
        waits   = 0;
        while (PREADY !== 1'b1 && waits < WAIT_LIMIT) begin
            tick();
            waits++;
        end
        chk({tag, ".waits"}, 32'(waits), 32'(EXP_WAITS));
        chk({tag, ".pready"}, {31'h0, PREADY}, 32'h1);
        chk({tag, ".pslverr"}, {31'h0, PSLVERR}, {31'h0, exp_err});
        if (!wr) chk({tag, ".prdata"}, PRDATA, data);
        tick();
        chk({tag, ".pready_pulse"}, {31'h0, PREADY}, 32'h0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        PRESET  = 1'b1;
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h0;
        PWDATA  = 32'hFFFF_FFFF;

        // Reset with the bus active
        tick();
        tick();
        chk("rst.pready", {31'h0, PREADY}, 32'h0);
        chk("rst.pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("rst.prdata", PRDATA, 32'h0);
        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 32'(4 * i), 32'h0, 1'b0, $sformatf("rst_rd%0d", i));
        end

        // Basic write then read
        xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 1'b0, "wr4");
        xfer(1'b0, 32'h4, 32'hDEAD_BEEF, 1'b0, "rd4");

        // Error decode
        xfer(1'b1, 32'h0, 32'hCAFE_F00D, 1'b0, "wr0");
        xfer(1'b0, 32'hFFFF_FFE5, 32'h0, 1'b1, "rd_bad");
        xfer(1'b1, 32'h40, 32'h1234_5678, 1'b1, "wr_oor");
        xfer(1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "rd0_after_err");
        xfer(1'b0, 32'h2, 32'h0, 1'b1, "rd_misaligned");
        xfer(1'b0, 32'h4, 32'hDEAD_BEEF, 1'b0, "rd4_after_err");

        // Top register, observed latency follows the build's wait count
        xfer(1'b1, 32'h3C, 32'hA5A5_A5A5, 1'b0, "wr3c");
        xfer(1'b0, 32'h3C, 32'hA5A5_A5A5, 1'b0, "rd3c");

        // Back-to-back with no idle cycles between transfers
        xfer(1'b1, 32'h0, 32'h1, 1'b0, "b2b_wr0");
        xfer(1'b1, 32'h4, 32'h2, 1'b0, "b2b_wr4");
        xfer(1'b1, 32'h8, 32'h3, 1'b0, "b2b_wr8");
        xfer(1'b0, 32'h0, 32'h1, 1'b0, "b2b_rd0");
        xfer(1'b0, 32'h4, 32'h2, 1'b0, "b2b_rd4");
        xfer(1'b0, 32'h8, 32'h3, 1'b0, "b2b_rd8");
        tick();

        // Abort by dropping PSEL mid-transfer
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h8;
        PWDATA  = 32'h55;
        tick();
`ifdef APB_SLV_WAIT_EN
        chk("abort.wait1", {31'h0, PREADY}, 32'h0);
        PENABLE = 1'b1;
        tick();
        chk("abort.wait2", {31'h0, PREADY}, 32'h0);
`else
        chk("abort.ready", {31'h0, PREADY}, 32'h1);
`endif
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort.idle%0d", i), {31'h0, PREADY}, 32'h0);
        end
        xfer(1'b0, 32'h8, 32'h3, 1'b0, "abort_rd8");

        // PENABLE without a setup phase is ignored
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h8;
        PWDATA  = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("nosetup%0d", i), {31'h0, PREADY}, 32'h0);
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        xfer(1'b0, 32'h8, 32'h3, 1'b0, "nosetup_rd8");

        // Reset in the middle of a write
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h8;
        PWDATA  = 32'h77;
        tick();
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        tick();
        chk("midrst.pready", {31'h0, PREADY}, 32'h0);
        chk("midrst.pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("midrst.prdata", PRDATA, 32'h0);
        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        tick();
        xfer(1'b0, 32'h8, 32'h0, 1'b0, "midrst_rd8");
        xfer(1'b0, 32'h4, 32'h0, 1'b0, "midrst_rd4");
        xfer(1'b0, 32'h3C, 32'h0, 1'b0, "midrst_rd3c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
